fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, fetch constants and the
// pc/instruction pair carried between fetch and operand fetch.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_SQUASH  = 2'd1,
        ST_BLOCKED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h6800_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_word_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer: output latch plus one skid slot behind it.
// The skid always drains into the latch before any newer word.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_insn,
    output logic        valid,
    output logic        skid_full,
    output logic [31:0] instruction,
    output logic [31:0] pc
);

    fetch_word_t skid_q;
    logic        load;

    assign load = !stall || !valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            skid_full   <= 1'b0;
            instruction <= '0;
            pc          <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            valid     <= 1'b0;
            skid_full <= 1'b0;
        end else if (load) begin
            if (skid_full) begin
                pc          <= skid_q.pc;
                instruction <= skid_q.insn;
                valid       <= 1'b1;
                skid_full   <= push;
                if (push) begin
                    skid_q <= '{pc: push_pc, insn: push_insn};
                end
            end else begin
                valid <= push;
                if (push) begin
                    pc          <= push_pc;
                    instruction <= push_insn;
                end
            end
        end else if (push) begin
            skid_q    <= '{pc: push_pc, insn: push_insn};
            skid_full <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requester with
// redirect squashing and a skid-buffered output toward operand fetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] instruction,
    output logic [31:0] PC
);

    fetch_state_t state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  target_q, target_d;
    logic [31:0]  branch_tgt;
    logic         armed_q;
    logic         ack;
    logic         push;
    logic         flush;
    logic         skid_full;

    assign branch_tgt = word_align(branchPC);
    assign imem_req   = !rst && (state_q != ST_BLOCKED);
    assign imem_addr  = addr_q;
    // The first post-reset cycle may still carry an ack for an abandoned request.
    assign ack        = imem_ack && imem_req && armed_q;
    assign flush      = isBranchTaken;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        target_d = target_q;
        push     = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (isBranchTaken) begin
                    if (ack) begin
                        addr_d = branch_tgt;
                    end else begin
                        target_d = branch_tgt;
                        state_d  = ST_SQUASH;
                    end
                end else if (ack) begin
                    push   = 1'b1;
                    addr_d = addr_q + PC_STEP;
                    if (valid && stall) begin
                        state_d = ST_BLOCKED;
                    end
                end
            end
            ST_SQUASH: begin
                if (isBranchTaken) begin
                    target_d = branch_tgt;
                end
                if (ack) begin
                    addr_d  = isBranchTaken ? branch_tgt : target_q;
                    state_d = ST_FETCH;
                end
            end
            ST_BLOCKED: begin
                if (isBranchTaken) begin
                    addr_d  = branch_tgt;
                    state_d = ST_FETCH;
                end else if (!skid_full || !stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            addr_q   <= word_align(RESET_PC);
            target_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            armed_q  <= 1'b1;
        end
    end

    fetch_buffer u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .push        (push),
        .push_pc     (addr_q),
        .push_insn   (imem_rdata),
        .valid       (valid),
        .skid_full   (skid_full),
        .instruction (instruction),
        .pc          (PC)
    );

endmodule
